chunked_addsub: RTL
===================

# chunked_addsub

Multi-cycle, parametrised two's-complement add/subtract unit that generalises the single-cycle add/sub-with-overflow datapath.
- Splits a WIDTH-bit operation into CHUNK-bit slices and processes one slice per clock, rippling the carry through a register.
- Produces the result, carry-out and a {zero, negative, overflow} status word.
- Sits between the register-read stage and write-back of the RISC datapath, behind a valid/ready handshake so the long-word ALU can trade latency for area.

## Interface
- WIDTH, 16: operand/result width in bits; must be an integer multiple of CHUNK and ≥ 2.
- CHUNK, 4: bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH. NCHUNK = WIDTH/CHUNK.

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset: asynchronous, active-low.
- in_valid  input  1  operands and sub are valid.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- a  input  WIDTH  operand A (signed two's complement).
- b  input  WIDTH  operand B (signed two's complement).
- sub  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result, status and carry_out are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  computed value (registered).
- status  output  3  {zero, negative, overflow} (bit 2, bit 1, bit 0).
- carry_out  output  1  carry out of the MSB. For a subtraction, 1 means no borrow.

## Operation
FSM states: IDLE, RUN, DONE.

- **IDLE**
  - in_ready = 1.
  - On in_valid & in_ready:
    - latch a into op_a and (b XOR {WIDTH{sub}}) into op_b;
    - set carry = sub, idx = 0, nz = 0;
    - go to RUN.
- **RUN**
  - Each cycle adds slice idx of op_a, op_b and carry.
  - Writes the CHUNK-bit sum into result[idx*CHUNK +: CHUNK] and the slice carry-out into carry.
  - Sets nz |= (slice sum ≠ 0), then increments idx.
  - On the slice where idx = NCHUNK−1:
    - overflow = (op_a[MSB] == op_b[MSB]) & (sum[MSB] ≠ op_a[MSB]);
    - carry_out = final carry;
    - negative = sum[MSB];
    - zero = ~nz_next;
    - go to DONE.
- **DONE**
  - out_valid = 1; result, status and carry_out are held stable.
  - On out_ready, go to IDLE.
  - in_valid is ignored in DONE; in_ready = 0.
- **Arithmetic**
  - Modular WIDTH-bit arithmetic.
  - The operand registers are not observable.
  - a and b may change after the accepting edge without affecting the operation.
- **Reset**
  - Applies at any time, including mid-RUN.
  - State goes to IDLE; result, status, carry_out, idx and carry go to 0; the in-flight operation is discarded.

## Timing
- Reset values: in_ready = 1, out_valid = 0, result = 0, status = 3'b000, carry_out = 0.
- Latency:
  - The operation is accepted on edge t.
  - out_valid rises after edge t+NCHUNK, i.e. NCHUNK cycles later.
  - With CHUNK = WIDTH the latency is 1 cycle.
- Throughput: one operation per NCHUNK+2 cycles at best (accept, NCHUNK RUN cycles, DONE handshake). Accept is not overlapped with DONE.
- Backpressure: out_valid stays high and outputs stay constant for as long as out_ready is low.
- out_ready high while out_valid is low has no effect.
- in_ready depends only on state, never on in_valid, so there is no combinational path from input to output.

## Configuration
- ADDSUB_SAT_EN defined: saturating mode.
  - On overflow, result = 0111…1 when op_a[MSB] = 0, else 1000…0.
  - overflow = 1 is still reported.
  - negative reflects the saturated result.
  - zero = 0.
  - carry_out is unchanged from the wrapped computation.
- ADDSUB_SAT_EN undefined: result wraps, with no saturation logic instantiated.

## Structure
- Package addsub_pkg:
  - FSM state enum (IDLE, RUN, DONE);
  - status bit-index constants STAT_Z = 2, STAT_N = 1, STAT_V = 0.
- Sub-module addsub_chunk:
  - purely combinational, parameter CHUNK;
  - inputs x, y, cin; outputs s, cout.
  - The top level instantiates it once and muxes the slices by idx.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
1. 0x1234 + 0x0001, sub=0 → result 0x1235, status 000, carry_out 0; out_valid exactly 4 cycles after accept.
2. 0x7FFF + 0x0001 → wrap: 0x8000, status 011. With ADDSUB_SAT_EN: 0x7FFF, status 001.
3. 0x0005 − 0x0005 → 0x0000, status 100, carry_out 1. Also 0x8000 − 0x0001 → 0x7FFF, status 001; with ADDSUB_SAT_EN 0x8000, status 011.
4. Backpressure: hold out_ready low 3 cycles in DONE with in_valid high → outputs stable, in_ready 0, no second accept. Release → IDLE next cycle, then the next operation is accepted.
5. Assert rst_n low during the 2nd RUN cycle → immediately in_ready 1, out_valid 0, result 0, status 000. A fresh 0x0003 + 0xFFFF afterwards → 0x0002, carry_out 1, status 000.
6. WIDTH=8, CHUNK=8: 0x80 + 0x80 → 0x00, status 101, carry_out 1, latency 1 cycle.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the chunked add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions inside the {zero, negative, overflow} status word.
  localparam int STAT_Z = 2;
  localparam int STAT_N = 1;
  localparam int STAT_V = 0;

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-bit slice of the ripple adder; purely combinational.
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle two's-complement add/subtract, one CHUNK-bit slice per clock.
// Optional build macro ADDSUB_SAT_EN selects saturating results on overflow.
module chunked_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       status,
  output logic             carry_out
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  // Slot table is padded to a power of two so idx never selects past its end.
  localparam int NSLOT  = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_t state, state_next;

  logic [WIDTH-1:0] op_a, op_b;
  logic             carry;
  logic             nz;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic [CHUNK-1:0] a_slot [NSLOT];
  logic [CHUNK-1:0] b_slot [NSLOT];
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             ovf;
  logic [2:0]       fin_status;

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < NCHUNK) begin : g_used
      assign a_slot[g] = op_a[g*CHUNK +: CHUNK];
      assign b_slot[g] = op_b[g*CHUNK +: CHUNK];
    end else begin : g_pad
      assign a_slot[g] = '0;
      assign b_slot[g] = '0;
    end
  end

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (a_slot[idx]),
    .y    (b_slot[idx]),
    .cin  (carry),
    .s    (slice_sum),
    .cout (slice_cout)
  );

  assign last = (idx == LAST_IDX);

  // op_b already holds ~b for a subtract, so the add-overflow rule covers both.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    fin_status         = '0;
    ovf                = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                         (slice_sum[CHUNK-1] != op_a[WIDTH-1]);
    fin_status[STAT_V] = ovf;
    fin_status[STAT_N] = slice_sum[CHUNK-1];
    fin_status[STAT_Z] = ~(nz | (|slice_sum));
`ifdef ADDSUB_SAT_EN
    if (ovf) begin
      fin_status[STAT_N] = op_a[WIDTH-1];
      fin_status[STAT_Z] = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last)     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      nz        <= 1'b0;
      idx       <= '0;
      result    <= '0;
      status    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= b ^ {WIDTH{sub}};
            carry <= sub;
            idx   <= '0;
            nz    <= 1'b0;
          end
        end
        RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDX_W'(i)) result[i*CHUNK +: CHUNK] <= slice_sum;
          end
          carry <= slice_cout;
          nz    <= nz | (|slice_sum);
          idx   <= idx + 1'b1;
          if (last) begin
            carry_out <= slice_cout;
            status    <= fin_status;
`ifdef ADDSUB_SAT_EN
            if (ovf) result <= op_a[WIDTH-1] ? SAT_NEG : SAT_POS;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
